// File: rtl/writeback_stage.sv
// Writeback stage: holds the M/W pipeline register, waits on variable-latency loads with a
// timeout, back-pressures the memory stage and keeps a saturating retire counter.
module writeback_stage #(
  parameter int WIDTH        = 8,
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidM,
  input  logic                 RegWriteM,
  input  logic                 MemtoRegM,
  input  logic                 PCSrcM,
  input  logic [3:0]           WA3M,
  input  logic [WIDTH-1:0]     ALUResultM,
  input  logic                 ReadValidM,
  input  logic [WIDTH-1:0]     ReadDataM,
  output logic                 StallM,
  output logic                 RegWriteW,
  output logic [3:0]           WA3W,
  output logic [WIDTH-1:0]     ResultW,
  output logic                 PCSrcW,
  output logic                 LoadErrW,
  output logic [CNT_WIDTH-1:0] RetireCnt
);

  localparam int TW = $clog2(LOAD_TIMEOUT);
  localparam logic [TW-1:0] WAIT_LAST = TW'(LOAD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WB, WAIT, ERR} state_t;

  state_t                 state, state_nxt;
  logic                   accept, load_done;
  logic                   reg_write_p0, mem_to_reg_p0, pc_src_p0;
  logic [3:0]             wa3_p0;
  logic [WIDTH-1:0]       alu_p0, load_p0;
  logic [TW-1:0]          wait_cnt;
  logic [CNT_WIDTH-1:0]   retire_cnt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign accept    = ValidM && (state != WAIT);
  assign load_done = (state == WAIT) && ReadValidM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    StallM    = 1'b0;
    RegWriteW = 1'b0;
    PCSrcW    = 1'b0;
    LoadErrW  = 1'b0;
    WA3W      = wa3_p0;
    ResultW   = mem_to_reg_p0 ? load_p0 : alu_p0;
    RetireCnt = retire_cnt;
    case (state)
      WAIT: begin
        StallM = 1'b1;
        // A response on the final wait cycle still wins over the timeout.
        if (ReadValidM)                 state_nxt = WB;
        else if (wait_cnt == WAIT_LAST) state_nxt = ERR;
      end
      default: begin
        if (state == WB) begin
          RegWriteW = reg_write_p0;
          PCSrcW    = pc_src_p0 & reg_write_p0;
        end
        if (state == ERR) LoadErrW = 1'b1;
        if (ValidM) state_nxt = MemtoRegM ? WAIT : WB;
        else        state_nxt = IDLE;
      end
    endcase
  end

  // M/W pipeline register and load data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_p0  <= 1'b0;
      mem_to_reg_p0 <= 1'b0;
      pc_src_p0     <= 1'b0;
      wa3_p0        <= '0;
      alu_p0        <= '0;
      load_p0       <= '0;
    end else begin
      if (accept) begin
        reg_write_p0  <= RegWriteM;
        mem_to_reg_p0 <= MemtoRegM;
        pc_src_p0     <= PCSrcM;
        wa3_p0        <= WA3M;
        alu_p0        <= ALUResultM;
      end
      if (load_done) load_p0 <= ReadDataM;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= '0;
      retire_cnt <= '0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
      if (state == WB) retire_cnt <= sat_inc(retire_cnt);
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized bench for writeback_stage: two instances (16-bit and 4-bit retire counters)
// share stimulus and are compared against an instruction-level reference model.
module tb_writeback_stage;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ValidM = 0, RegWriteM = 0, MemtoRegM = 0, PCSrcM = 0, ReadValidM = 0;
  logic [3:0] WA3M = '0;
  logic [W-1:0] ALUResultM = '0, ReadDataM = '0;

  logic stall_a, rw_a, pc_a, err_a, stall_b, rw_b, pc_b, err_b;
  logic [3:0] wa_a, wa_b;
  logic [W-1:0] res_a, res_b;
  logic [15:0] cnt_a;
  logic [3:0] cnt_b;

  int checks = 0;
  int failures = 0;
  int exp_retire = 0;

  always #5 clk = ~clk;

  writeback_stage #(.WIDTH(W), .LOAD_TIMEOUT(TO), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM), .WA3M(WA3M), .ALUResultM(ALUResultM), .ReadValidM(ReadValidM),
    .ReadDataM(ReadDataM), .StallM(stall_a), .RegWriteW(rw_a), .WA3W(wa_a), .ResultW(res_a),
    .PCSrcW(pc_a), .LoadErrW(err_a), .RetireCnt(cnt_a));

  writeback_stage #(.WIDTH(W), .LOAD_TIMEOUT(TO), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM), .WA3M(WA3M), .ALUResultM(ALUResultM), .ReadValidM(ReadValidM),
    .ReadDataM(ReadDataM), .StallM(stall_b), .RegWriteW(rw_b), .WA3W(wa_b), .ResultW(res_b),
    .PCSrcW(pc_b), .LoadErrW(err_b), .RetireCnt(cnt_b));

  function automatic logic [7:0] ctrl();
    return {stall_a, rw_a, pc_a, err_a, stall_b, rw_b, pc_b, err_b};
  endfunction

  function automatic logic [3:0] sat4(input int n);
    return (n > 15) ? 4'hF : 4'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ValidM = 0; RegWriteM = 0; MemtoRegM = 0; PCSrcM = 0; ReadValidM = 0;
    WA3M = '0; ALUResultM = '0; ReadDataM = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ValidM = 1'($urandom); RegWriteM = 1'($urandom); MemtoRegM = 1'($urandom);
      PCSrcM = 1'($urandom); WA3M = 4'($urandom); ALUResultM = 8'($urandom);
      ReadValidM = 1'($urandom); ReadDataM = 8'($urandom);
      step();
      checks++;
      if ({ctrl(), wa_a, res_a, wa_b, res_b, cnt_a, cnt_b} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got=%h required=0", i,
                 {ctrl(), wa_a, res_a, wa_b, res_b, cnt_a, cnt_b});
      end
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    exp_retire = 0;
    step();
    checks++;
    if ({ctrl(), cnt_a} !== '0) begin
      failures++;
      $display("FAIL reset_release got=%h required=0", {ctrl(), cnt_a});
    end
  endtask

  task automatic test_alu_stream();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      ValidM = 1; RegWriteM = 1; MemtoRegM = 0; PCSrcM = 0;
      WA3M = 4'(i + 1); ALUResultM = vals[i];
      step();
      if (i > 0) exp_retire++;
      checks++;
      if (ctrl() !== 8'b0100_0100) begin
        failures++;
        $display("FAIL alu_stream_ctrl i=%0d got=%b required=01000100", i, ctrl());
      end
      checks++;
      if ({wa_a, res_a, wa_b, res_b} !== {4'(i + 1), vals[i], 4'(i + 1), vals[i]}) begin
        failures++;
        $display("FAIL alu_stream_data i=%0d got=%h required=%h", i,
                 {wa_a, res_a, wa_b, res_b}, {4'(i + 1), vals[i], 4'(i + 1), vals[i]});
      end
    end
    idle_inputs();
    step();
    exp_retire++;
    checks++;
    if ({ctrl(), cnt_a, cnt_b} !== {8'h00, 16'(exp_retire), sat4(exp_retire)}) begin
      failures++;
      $display("FAIL alu_stream_end got=%h required=%h", {ctrl(), cnt_a, cnt_b},
               {8'h00, 16'(exp_retire), sat4(exp_retire)});
    end
  endtask

  task automatic test_random_alu(input int n);
    logic pv, prw, ppc;
    logic [3:0] pwa;
    logic [7:0] pval, ec;
    pv = 0; prw = 0; ppc = 0; pwa = '0; pval = '0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        ValidM = ($urandom_range(0, 3) != 0); RegWriteM = 1'($urandom);
        PCSrcM = 1'($urandom); WA3M = 4'($urandom); ALUResultM = 8'($urandom);
        ReadValidM = 1'($urandom); ReadDataM = 8'($urandom);
      end else idle_inputs();
      MemtoRegM = 0;
      step();
      if (pv) exp_retire++;
      pv = ValidM; prw = RegWriteM; ppc = PCSrcM; pwa = WA3M; pval = ALUResultM;
      ec = {1'b0, pv & prw, pv & prw & ppc, 1'b0, 1'b0, pv & prw, pv & prw & ppc, 1'b0};
      checks++;
      if ({ctrl(), cnt_a, cnt_b} !== {ec, 16'(exp_retire), sat4(exp_retire)}) begin
        failures++;
        $display("FAIL random_alu_ctrl i=%0d got=%h required=%h", i, {ctrl(), cnt_a, cnt_b},
                 {ec, 16'(exp_retire), sat4(exp_retire)});
      end
      if (pv) begin
        checks++;
        if ({wa_a, res_a, wa_b, res_b} !== {pwa, pval, pwa, pval}) begin
          failures++;
          $display("FAIL random_alu_data i=%0d got=%h required=%h", i,
                   {wa_a, res_a, wa_b, res_b}, {pwa, pval, pwa, pval});
        end
      end
    end
  endtask

  task automatic test_load(input int lat, input bit respond, input bit rw,
                           input logic [3:0] wa, input logic [7:0] data);
    logic [3:0] fwa;
    logic [7:0] fval, ec;
    logic fpc;
    int n;
    fwa = 4'($urandom); fval = 8'($urandom); fpc = 1'($urandom);
    ValidM = 1; MemtoRegM = 1; RegWriteM = rw; PCSrcM = 0; WA3M = wa;
    ALUResultM = 8'($urandom); ReadValidM = 1; ReadDataM = ~data;
    step();
    MemtoRegM = 0; RegWriteM = 1; PCSrcM = fpc; WA3M = fwa; ALUResultM = fval;
    n = respond ? lat : TO;
    for (int i = 0; i < n; i++) begin
      ReadValidM = respond && (i == lat - 1);
      ReadDataM  = (respond && i == lat - 1) ? data : 8'($urandom);
      checks++;
      if (ctrl() !== 8'b1000_1000) begin
        failures++;
        $display("FAIL load_wait lat=%0d i=%0d got=%b required=10001000", lat, i, ctrl());
      end
      step();
    end
    ReadValidM = !respond;
    ReadDataM = 8'($urandom);
    ec = respond ? {1'b0, rw, 2'b00, 1'b0, rw, 2'b00} : 8'b0001_0001;
    checks++;
    if ({ctrl(), cnt_a} !== {ec, 16'(exp_retire)}) begin
      failures++;
      $display("FAIL load_result_ctrl lat=%0d resp=%0d got=%h required=%h", lat, respond,
               {ctrl(), cnt_a}, {ec, 16'(exp_retire)});
    end
    if (respond && rw) begin
      checks++;
      if ({wa_a, res_a, wa_b, res_b} !== {wa, data, wa, data}) begin
        failures++;
        $display("FAIL load_result_data lat=%0d got=%h required=%h", lat,
                 {wa_a, res_a, wa_b, res_b}, {wa, data, wa, data});
      end
    end
    step();
    if (respond) exp_retire++;
    ReadValidM = 0;
    ec = {1'b0, 1'b1, fpc, 1'b0, 1'b0, 1'b1, fpc, 1'b0};
    checks++;
    if ({ctrl(), wa_a, res_a} !== {ec, fwa, fval}) begin
      failures++;
      $display("FAIL load_follower got=%h required=%h", {ctrl(), wa_a, res_a}, {ec, fwa, fval});
    end
    idle_inputs();
    step();
    exp_retire++;
    checks++;
    if ({ctrl(), cnt_a, cnt_b} !== {8'h00, 16'(exp_retire), sat4(exp_retire)}) begin
      failures++;
      $display("FAIL load_retire got=%h required=%h", {ctrl(), cnt_a, cnt_b},
               {8'h00, 16'(exp_retire), sat4(exp_retire)});
    end
  endtask

  task automatic test_pcsrc();
    ValidM = 1; RegWriteM = 1; MemtoRegM = 0; PCSrcM = 1; WA3M = 4'd15; ALUResultM = 8'h5C;
    step();
    checks++;
    if ({ctrl(), wa_a, res_a} !== {8'b0110_0110, 4'd15, 8'h5C}) begin
      failures++;
      $display("FAIL pcsrc_write got=%h required=%h", {ctrl(), wa_a, res_a},
               {8'b0110_0110, 4'd15, 8'h5C});
    end
    RegWriteM = 0;
    step();
    exp_retire++;
    checks++;
    if (ctrl() !== 8'h00) begin
      failures++;
      $display("FAIL pcsrc_no_regwrite got=%b required=00000000", ctrl());
    end
    idle_inputs();
    step();
    exp_retire++;
    checks++;
    if ({cnt_a, cnt_b} !== {16'(exp_retire), sat4(exp_retire)}) begin
      failures++;
      $display("FAIL pcsrc_retire got=%h required=%h", {cnt_a, cnt_b},
               {16'(exp_retire), sat4(exp_retire)});
    end
  endtask

  task automatic test_reset_mid_wait();
    ValidM = 1; MemtoRegM = 1; RegWriteM = 1; WA3M = 4'd9; ALUResultM = 8'h40;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (ctrl() !== 8'b1000_1000) begin
      failures++;
      $display("FAIL midwait_stall got=%b required=10001000", ctrl());
    end
    #2 reset = 1'b0;
    #1;
    exp_retire = 0;
    checks++;
    if ({ctrl(), wa_a, res_a, cnt_a, cnt_b} !== '0) begin
      failures++;
      $display("FAIL midwait_reset got=%h required=0", {ctrl(), wa_a, res_a, cnt_a, cnt_b});
    end
    ReadValidM = 1; ReadDataM = 8'hE7;
    @(negedge clk);
    reset = 1'b1;
    step();
    ReadValidM = 0;
    step();
    checks++;
    if ({ctrl(), cnt_a} !== '0) begin
      failures++;
      $display("FAIL midwait_no_write got=%h required=0", {ctrl(), cnt_a});
    end
  endtask

  task automatic test_saturation();
    reset = 1'b0;
    step();
    @(negedge clk);
    reset = 1'b1;
    exp_retire = 0;
    for (int i = 0; i < 20; i++) begin
      ValidM = 1; RegWriteM = 1; MemtoRegM = 0; PCSrcM = 0;
      WA3M = 4'($urandom); ALUResultM = 8'($urandom);
      step();
      if (i > 0) exp_retire++;
      checks++;
      if ({rw_a, cnt_a, cnt_b} !== {1'b1, 16'(exp_retire), sat4(exp_retire)}) begin
        failures++;
        $display("FAIL saturation_step i=%0d got=%h required=%h", i, {rw_a, cnt_a, cnt_b},
                 {1'b1, 16'(exp_retire), sat4(exp_retire)});
      end
    end
    idle_inputs();
    step();
    exp_retire++;
    checks++;
    if ({cnt_a, cnt_b} !== {16'd20, 4'hF}) begin
      failures++;
      $display("FAIL saturation_final got=%h required=%h", {cnt_a, cnt_b}, {16'd20, 4'hF});
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_random_alu(60);
    test_load(4, 1'b1, 1'b1, 4'd5, 8'hA5);
    test_load(0, 1'b0, 1'b1, 4'($urandom), 8'($urandom));
    test_load(TO, 1'b1, 1'b1, 4'($urandom), 8'($urandom));
    test_load(1, 1'b1, 1'b1, 4'($urandom), 8'($urandom));
    for (int k = 0; k < 6; k++)
      test_load(int'($urandom_range(1, TO)), ($urandom_range(0, 3) != 0), 1'($urandom),
                4'($urandom), 8'($urandom));
    test_pcsrc();
    test_reset_mid_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
